// File: rtl/filter_pkg.sv
// Shared types and helpers for the 3x3 line-buffer filter frame sequencer.
// Holds the sequencer phase encoding, pixel width and padding helper.
package filter_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_PAD_TOP = 3'd1,
    SEQ_BODY    = 3'd2,
    SEQ_PAD_BOT = 3'd3,
    SEQ_FLUSH   = 3'd4
  } seq_state_t;

  function automatic int PAD_OF(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/filter_frame_sequencer_pos_cnt.sv
// Column/row position counter for the padded frame walk.
// Column wraps at COL_LAST; row wraps at row_last and flags the phase end.
module filter_seq_pos_cnt #(
  parameter int COL_LAST = 5,
  parameter int COL_W    = 3,
  parameter int ROW_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  input  logic [ROW_W-1:0] row_last,
  output logic [COL_W-1:0] col,
  output logic             phase_end
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_wrap;
  logic             row_wrap;

  assign col_wrap  = (col_q == COL_W'(COL_LAST));
  assign row_wrap  = (row_q == row_last);
  assign phase_end = adv & col_wrap & row_wrap;
  assign col       = col_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame sequencer: pads the pixel stream, flushes the filter, counts outputs.
// Optional FILTER_SEQ_STALL_CNT_EN adds a BODY input-stall counter.
module filter_frame_sequencer
  import filter_pkg::*;
#(
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 240,
  parameter int KERNEL_SIZE  = 3,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             filt_valid,
  output logic [PIX_W-1:0] filt_data,
  input  logic             filt_o_valid,
  input  logic [PIX_W-1:0] filt_o_data,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic [17:0]      out_pix_cnt,
  output logic             cnt_err
`ifdef FILTER_SEQ_STALL_CNT_EN
  ,
  output logic [19:0]      stall_cnt
`endif
);

  localparam int PAD     = PAD_OF(KERNEL_SIZE);
  localparam int ROW_LEN = WIDTH + 2 * PAD;
  localparam int COL_W   = $clog2(ROW_LEN + 1);
  localparam int ROW_W   = $clog2(HEIGHT + 1);
  localparam int FL_W    = $clog2(FLUSH_CYCLES + 1);

  localparam logic [2:0] IDLE    = SEQ_IDLE;
  localparam logic [2:0] PAD_TOP = SEQ_PAD_TOP;
  localparam logic [2:0] BODY    = SEQ_BODY;
  localparam logic [2:0] PAD_BOT = SEQ_PAD_BOT;
  localparam logic [2:0] FLUSH   = SEQ_FLUSH;

  logic [2:0]       state_q, state_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic             filt_valid_q;
  logic [PIX_W-1:0] filt_data_q, filt_data_d;
  logic             frame_done_q, frame_done_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q;
  logic [17:0]      pix_cnt_q, pix_cnt_d, pix_cnt_nx;
  logic             cnt_err_q, cnt_err_d;

  logic             strobe;
  logic [PIX_W-1:0] pix;
  logic             adv;
  logic             clr;
  logic             start_acc;
  logic             interior;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row_last;
  logic             phase_end;

  filter_seq_pos_cnt #(
    .COL_LAST (ROW_LEN - 1),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .adv       (adv),
    .row_last  (row_last),
    .col       (col),
    .phase_end (phase_end)
  );

  assign interior  = (col >= COL_W'(PAD)) && (col < COL_W'(WIDTH + PAD));
  assign in_ready  = (state_q == BODY) && interior;
  assign row_last  = (state_q == BODY) ? ROW_W'(HEIGHT - 1) : ROW_W'(PAD - 1);
  assign start_acc = (state_q == IDLE) && start && !frame_done_q;

  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    frame_done_d = 1'b0;
    strobe       = 1'b0;
    pix          = '0;
    adv          = 1'b0;
    clr          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = PAD_TOP;
          clr     = 1'b1;
        end
      end
      PAD_TOP: begin
        strobe = 1'b1;
        adv    = 1'b1;
        if (phase_end) state_d = BODY;
      end
      BODY: begin
        // interior columns stall the walk when upstream has no pixel
        strobe = interior ? in_valid : 1'b1;
        pix    = interior ? in_data : '0;
        adv    = strobe;
        if (phase_end) state_d = PAD_BOT;
      end
      PAD_BOT: begin
        strobe = 1'b1;
        adv    = 1'b1;
        if (phase_end) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end
      FLUSH: begin
        // one trailing idle cycle lets the last strobe land before done
        strobe = (flush_q != FL_W'(FLUSH_CYCLES));
        if (flush_q == FL_W'(FLUSH_CYCLES)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign filt_data_d = strobe ? pix : '0;
  assign out_valid_d = filt_o_valid && (state_q != IDLE);

  always_comb begin
    pix_cnt_nx = pix_cnt_q;
    if (out_valid_q && (pix_cnt_q != '1)) pix_cnt_nx = pix_cnt_q + 1'b1;
    pix_cnt_d = start_acc ? '0 : pix_cnt_nx;
    cnt_err_d = cnt_err_q |
                (frame_done_q && (pix_cnt_nx != 18'(WIDTH * HEIGHT)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      flush_q      <= '0;
      filt_valid_q <= 1'b0;
      filt_data_q  <= '0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      pix_cnt_q    <= '0;
      cnt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      filt_valid_q <= strobe;
      filt_data_q  <= filt_data_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= filt_o_data;
      pix_cnt_q    <= pix_cnt_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign filt_valid  = filt_valid_q;
  assign filt_data   = filt_data_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_pix_cnt = pix_cnt_q;
  assign cnt_err     = cnt_err_q;

`ifdef FILTER_SEQ_STALL_CNT_EN
  logic [19:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) stall_d = '0;
    else if (in_ready && !in_valid && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Scoreboard bench for filter_frame_sequencer at 4x3, 3x3 kernel, 16 flush.
// Driver, filter model and monitor run as separate negedge processes.
module tb_filter_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        filt_o_valid = 1'b0;
  logic [23:0] filt_o_data = '0;
  logic        busy, frame_done, in_ready, filt_valid;
  logic        out_valid, cnt_err;
  logic [23:0] filt_data, out_data;
  logic [17:0] out_pix_cnt;
`ifdef FILTER_SEQ_STALL_CNT_EN
  logic [19:0] stall_cnt;
`endif

  filter_frame_sequencer #(
    .WIDTH        (4),
    .HEIGHT       (3),
    .KERNEL_SIZE  (3),
    .FLUSH_CYCLES (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .filt_valid   (filt_valid),
    .filt_data    (filt_data),
    .filt_o_valid (filt_o_valid),
    .filt_o_data  (filt_o_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_pix_cnt  (out_pix_cnt),
    .cnt_err      (cnt_err)
`ifdef FILTER_SEQ_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] exp_filt[$];
  logic [23:0] exp_out[$];
  logic [23:0] px_q[$];

  bit mon_en   = 1'b0;
  bit model_en = 1'b0;
  bit force_o  = 1'b0;
  int mpos = 0, memit = 0, mlimit = 0;
  int sent_n = 0, stall_idx = -1, stall_rem = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exv);
    end
  endtask

  // upstream source with optional stall window
  always @(negedge clk) begin
    if (px_q.size() > 0) begin
      if (sent_n == stall_idx && stall_rem > 0) begin
        in_valid = 1'b0;
        #1;
        chk("in_ready_during_stall", {31'd0, in_ready}, 32'd1);
        stall_rem--;
      end else begin
        in_valid = 1'b1;
        in_data  = px_q[0];
        #1;
        if (in_ready) begin
          void'(px_q.pop_front());
          sent_n++;
        end
      end
    end else begin
      in_valid = 1'b0;
    end
  end

  // filter model: one output per complete 3x3 window, center rows/cols
  always @(negedge clk) begin
    filt_o_valid = force_o;
    filt_o_data  = force_o ? 24'h123456 : 24'h0;
    if (model_en && filt_valid) begin
      if (mpos < 30 && mpos / 6 >= 2 && mpos % 6 >= 2 && memit < mlimit) begin
        filt_o_valid = 1'b1;
        filt_o_data  = 24'hA00000 + 24'(memit);
        exp_out.push_back(filt_o_data);
        memit++;
      end
      mpos++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (filt_valid) begin
        if (exp_filt.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL filt_extra_strobe: got %0h expected none", filt_data);
        end else begin
          chk("filt_data", {8'd0, filt_data}, {8'd0, exp_filt.pop_front()});
        end
      end
      if (out_valid) begin
        if (exp_out.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL out_extra: got %0h expected none", out_data);
        end else begin
          chk("out_data", {8'd0, out_data}, {8'd0, exp_out.pop_front()});
        end
      end
    end
  end

  task automatic load_frame(input int f);
    logic [23:0] pix [12];
    exp_filt.delete();
    exp_out.delete();
    px_q.delete();
    for (int k = 0; k < 12; k++) begin
      pix[k] = {4'(f), 4'h5, 8'(k), 8'(8'h80 + k)};
      px_q.push_back(pix[k]);
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++)
        if (r >= 1 && r <= 3 && c >= 1 && c <= 4)
          exp_filt.push_back(pix[(r - 1) * 4 + (c - 1)]);
        else
          exp_filt.push_back(24'h0);
    for (int k = 0; k < 16; k++) exp_filt.push_back(24'h0);
    sent_n = 0;
  endtask

  task automatic run_frame(input int f, input int sidx, input int slen,
                           input int lim, input int exp_cnt,
                           input int exp_err);
    int  t0 = -1;
    int  tdone = -1;
    int  ndone = 0;
    bit  fin = 1'b0;
    load_frame(f);
    mpos = 0;
    memit = 0;
    mlimit = lim;
    stall_idx = sidx;
    stall_rem = slen;
    mon_en = 1'b1;
    model_en = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && t0 < 0) t0 = i;
      if (i == 12) start = 1'b1;
      if (frame_done) begin
        ndone++;
        if (tdone < 0) begin
          tdone = i;
          start = 1'b1;
        end
      end
      if (tdone >= 0 && i == tdone + 6) fin = 1'b1;
    end
    start = 1'b0;
    chk("frame_done_seen", {31'd0, tdone >= 0}, 32'd1);
    chk("busy_to_done", 32'(tdone - t0), 32'(47 + slen));
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("filt_left", 32'(exp_filt.size()), 32'd0);
    chk("out_left", 32'(exp_out.size()), 32'd0);
    chk("px_left", 32'(px_q.size()), 32'd0);
    chk("out_pix_cnt", {14'd0, out_pix_cnt}, 32'(exp_cnt));
    chk("cnt_err", {31'd0, cnt_err}, 32'(exp_err));
`ifdef FILTER_SEQ_STALL_CNT_EN
    chk("stall_cnt", {12'd0, stall_cnt}, 32'(slen));
`endif
    stall_idx = -1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_filt_valid", {31'd0, filt_valid}, 32'd0);
    chk("rst_filt_data", {8'd0, filt_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt", {14'd0, out_pix_cnt}, 32'd0);
    chk("rst_cnt_err", {31'd0, cnt_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    force_o = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end
    force_o = 1'b0;
    @(negedge clk);
    chk("idle_cnt", {14'd0, out_pix_cnt}, 32'd0);

    run_frame(1, -1, 0, 12, 12, 0);
    run_frame(2, 5, 5, 12, 12, 0);
    run_frame(3, -1, 0, 11, 11, 1);
    run_frame(4, -1, 0, 12, 12, 1);

    // abort a frame mid-BODY with reset
    load_frame(5);
    mon_en = 1'b0;
    model_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && sent_n < 6; i++) @(negedge clk);
    chk("abort_in_body", {31'd0, sent_n >= 6 && busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_filt_valid", {31'd0, filt_valid}, 32'd0);
    chk("abort_cnt", {14'd0, out_pix_cnt}, 32'd0);
    chk("abort_cnt_err", {31'd0, cnt_err}, 32'd0);
    px_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", {31'd0, frame_done}, 32'd0);

    run_frame(6, -1, 0, 12, 12, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
